// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data-memory responder with valid/ready request and response handshakes.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic wr;
  logic [31:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic accept, access, oor;
  assign accept = state == IDLE && req_valid && req_ready;
  // cnt counts down to 0 so the access lands exactly LATENCY edges after the accept
  assign access = state == WAIT && cnt == 4'd0;
  assign oor = |addr[31:ADDR_WIDTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      wr        <= req_write;
      addr      <= req_addr;
      wdata     <= req_wdata;
      cnt       <= 4'(LATENCY - 1);
      req_ready <= 1'b0;
      busy      <= 1'b1;
      state     <= WAIT;
    end else if (state == IDLE) begin
      req_ready <= 1'b1;
    end else if (access) begin
      resp_valid <= 1'b1;
      resp_err   <= oor;
      resp_rdata <= (!wr && !oor) ? mem[addr[ADDR_WIDTH-1:0]] : '0;
      state      <= RESP;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end else if (state == RESP && resp_ready) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      state      <= IDLE;
    end
  // a reset forces state to IDLE asynchronously, which also cancels a pending store
  always_ff @(posedge clk)
    if (access && wr && !oor) mem[addr[ADDR_WIDTH-1:0]] <= wdata;
endmodule
